regfile_scoreboard: RTL and testbench

//  - Architectural register file for the 5-stage pipeline: 32 x 32-bit, two combinational read ports, one write port.
//  - Consumes the read/write selects and write enable from the FD-stage read/writeback control logic.
//  - Adds a one-entry multdiv scoreboard: flags FD-stage reads of a register awaiting a multiply/divide result,
//    so the hazard unit can stall.

---
 rtl/regfile_scoreboard_pkg.sv | 25 ++
 rtl/regfile_read_port.sv | 31 +++
 rtl/regfile_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Constants and types shared by the register file, its read ports and the FD-stage control.
package regfile_scoreboard_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int LINK_REG = 31;

  // Opcode set decoded by the read/write control in front of this block
  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_J    = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_JAL  = 4'd3;
  localparam logic [3:0] OP_JR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_BLT  = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_PEND = 1'b1
  } sbState_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: r0 forcing, write-through bypass and multdiv busy flag.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
(
  input  logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] storedData,
  input  logic              wE,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              pending,
  input  logic [ADDR_W-1:0] pendDest,
  input  logic              mdDone,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic selIsZero;
  assign selIsZero = (sel == ADDR_W'(REG_ZERO));

  always_comb begin
    data = storedData;
    if (selIsZero)
      data = '0;
    else if (wE && (writeReg == sel))
      data = writeData;
  end

  // A completing multdiv delivers its result through the bypass, so no stall that cycle
  assign busy = pending && (sel == pendDest) && !selIsZero && !mdDone;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 architectural register file with a one-entry multdiv destination scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ctrl_wE,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_dest,
  input  logic              md_done,
  output logic              busyA,
  output logic              busyB,
  output logic              md_pending
);

  logic [DATA_W-1:0] regs [2**ADDR_W];
  sbState_t          state;
  logic [ADDR_W-1:0] pendDest;
  logic              writeLive;
  logic              issueLive;

  assign writeLive = ctrl_wE && (ctrl_writeReg != ADDR_W'(REG_ZERO));
  assign issueLive = md_issue && (md_dest != ADDR_W'(REG_ZERO));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    end else if (writeLive) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // A retiring op and a newly issued one in the same cycle hand the entry straight over
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SB_IDLE;
      pendDest <= '0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (issueLive) begin
            state    <= SB_PEND;
            pendDest <= md_dest;
          end
        end
        SB_PEND: begin
          if (md_done) begin
            if (issueLive) pendDest <= md_dest;
            else           state    <= SB_IDLE;
          end
        end
        default: state <= SB_IDLE;
      endcase
    end
  end

  assign md_pending = (state == SB_PEND);

  // The multdiv unit is not pipelined, so a new issue must coincide with the old result
  noOverlapIssue: assert property (@(posedge clock) disable iff (!reset_n)
    !(md_pending && md_issue && !md_done));

  regfile_read_port portA (
    .sel        (ctrl_readRegA),
    .storedData (regs[ctrl_readRegA]),
    .wE         (ctrl_wE),
    .writeReg   (ctrl_writeReg),
    .writeData  (data_writeReg),
    .pending    (md_pending),
    .pendDest   (pendDest),
    .mdDone     (md_done),
    .data       (data_readRegA),
    .busy       (busyA)
  );

  regfile_read_port portB (
    .sel        (ctrl_readRegB),
    .storedData (regs[ctrl_readRegB]),
    .wE         (ctrl_wE),
    .writeReg   (ctrl_writeReg),
    .writeData  (data_writeReg),
    .pending    (md_pending),
    .pendDest   (pendDest),
    .mdDone     (md_done),
    .data       (data_readRegB),
    .busy       (busyB)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard with an expected-result queue and reset corner cases.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset_n;
  logic        ctrl_wE;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        md_issue;
  logic [4:0]  md_dest;
  logic        md_done;
  logic        busyA;
  logic        busyB;
  logic        md_pending;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    logic        wE;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rA;
    logic [4:0]  rB;
    logic        issue;
    logic [4:0]  dest;
    logic        done;
    logic [31:0] expA;
    logic [31:0] expB;
    logic        expBusyA;
    logic        expBusyB;
    logic        expPend;
  } vec_t;

  typedef struct {
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busyA;
    logic        busyB;
    logic        pend;
  } exp_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  exp_t expQ [$];

  regfile_scoreboard dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_wE       (ctrl_wE),
    .ctrl_writeReg (ctrl_writeReg),
    .data_writeReg (data_writeReg),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .md_issue      (md_issue),
    .md_dest       (md_dest),
    .md_done       (md_done),
    .busyA         (busyA),
    .busyB         (busyB),
    .md_pending    (md_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    ctrl_wE       = v.wE;
    ctrl_writeReg = v.wr;
    data_writeReg = v.wd;
    ctrl_readRegA = v.rA;
    ctrl_readRegB = v.rB;
    md_issue      = v.issue;
    md_dest       = v.dest;
    md_done       = v.done;
    e.dataA = v.expA;
    e.dataB = v.expB;
    e.busyA = v.expBusyA;
    e.busyB = v.expBusyB;
    e.pend  = v.expPend;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (expQ.size() == 0) begin
      totalCount++;
      $display("[TB] FAIL v%0d queue: got empty, expected an entry", idx);
      return;
    end
    e = expQ.pop_front();
    checkVal($sformatf("v%0d dataA", idx), data_readRegA, e.dataA);
    checkVal($sformatf("v%0d dataB", idx), data_readRegB, e.dataB);
    checkVal($sformatf("v%0d busyA", idx), {31'd0, busyA}, {31'd0, e.busyA});
    checkVal($sformatf("v%0d busyB", idx), {31'd0, busyB}, {31'd0, e.busyB});
    checkVal($sformatf("v%0d pending", idx), {31'd0, md_pending}, {31'd0, e.pend});
  endtask

  task automatic idleInputs();
    ctrl_wE = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
    ctrl_readRegA = '0; ctrl_readRegB = '0;
    md_issue = 1'b0; md_dest = '0; md_done = 1'b0;
  endtask

  initial begin
    //           wE  wr     wd            rA     rB     iss dest   done expA          expB          bA bB pend
    vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  0, 5'd0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[1]  = '{1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd0,  0, 5'd0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[2]  = '{0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  0, 32'h0,        32'h0,        0, 0, 0};
    vecs[3]  = '{1, 5'd7,  32'h11,       5'd7,  5'd5,  0, 5'd0,  0, 32'h11,       32'hDEADBEEF, 0, 0, 0};
    vecs[4]  = '{1, 5'd7,  32'h22,       5'd7,  5'd7,  0, 5'd0,  0, 32'h22,       32'h22,       0, 0, 0};
    vecs[5]  = '{0, 5'd0,  32'h0,        5'd7,  5'd7,  0, 5'd0,  0, 32'h22,       32'h22,       0, 0, 0};
    vecs[6]  = '{0, 5'd0,  32'h0,        5'd13, 5'd12, 1, 5'd12, 0, 32'h0,        32'h0,        0, 0, 0};
    vecs[7]  = '{0, 5'd0,  32'h0,        5'd13, 5'd12, 0, 5'd0,  0, 32'h0,        32'h0,        0, 1, 1};
    vecs[8]  = '{1, 5'd12, 32'h64,       5'd13, 5'd12, 0, 5'd0,  1, 32'h0,        32'h64,       0, 0, 1};
    vecs[9]  = '{0, 5'd0,  32'h0,        5'd12, 5'd12, 0, 5'd0,  0, 32'h64,       32'h64,       0, 0, 0};
    vecs[10] = '{0, 5'd0,  32'h0,        5'd12, 5'd9,  1, 5'd12, 0, 32'h64,       32'h0,        0, 0, 0};
    vecs[11] = '{1, 5'd12, 32'h99,       5'd12, 5'd9,  1, 5'd9,  1, 32'h99,       32'h0,        0, 0, 1};
    vecs[12] = '{0, 5'd0,  32'h0,        5'd12, 5'd9,  0, 5'd0,  0, 32'h99,       32'h0,        0, 1, 1};
    vecs[13] = '{0, 5'd0,  32'h0,        5'd9,  5'd12, 0, 5'd0,  0, 32'h0,        32'h99,       1, 0, 1};
    vecs[14] = '{1, 5'd9,  32'h123,      5'd9,  5'd9,  0, 5'd0,  1, 32'h123,      32'h123,      0, 0, 1};
    vecs[15] = '{0, 5'd0,  32'h0,        5'd0,  5'd9,  1, 5'd0,  0, 32'h0,        32'h123,      0, 0, 0};
    vecs[16] = '{0, 5'd0,  32'h0,        5'd9,  5'd31, 0, 5'd0,  1, 32'h123,      32'h0,        0, 0, 0};
    vecs[17] = '{0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  0, 32'h0,        32'h0,        0, 0, 0};
    vecs[18] = '{1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 0, 5'd0,  0, 32'hCAFEF00D, 32'h0,        0, 0, 0};
    vecs[19] = '{0, 5'd0,  32'h0,        5'd31, 5'd30, 0, 5'd0,  0, 32'hCAFEF00D, 32'h0,        0, 0, 0};

    idleInputs();
    reset_n = 1'b0;
    ctrl_readRegA = 5'd5;
    #1;
    checkVal("reset dataA", data_readRegA, 32'h0);
    checkVal("reset pending", {31'd0, md_pending}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput(i);
      @(posedge clock);
      #1;
    end

    // Issue into r3, then pull reset mid-cycle with the entry pending
    idleInputs();
    md_issue = 1'b1;
    md_dest  = 5'd3;
    @(posedge clock);
    #1;
    idleInputs();
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd3;
    #2;
    checkVal("pre-reset dataA", data_readRegA, 32'hDEADBEEF);
    checkVal("pre-reset busyB", {31'd0, busyB}, 32'h1);
    checkVal("pre-reset pending", {31'd0, md_pending}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkVal("async reset dataA", data_readRegA, 32'h0);
    checkVal("async reset pending", {31'd0, md_pending}, 32'h0);
    checkVal("async reset busyB", {31'd0, busyB}, 32'h0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd31;
    @(posedge clock);
    #1;
    checkVal("post-reset r7", data_readRegA, 32'h0);
    checkVal("post-reset r31", data_readRegB, 32'h0);
    checkVal("post-reset pending", {31'd0, md_pending}, 32'h0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
